prio_encoder_seq: RTL and testbench
===================================

// Module: prio_encoder_seq
// PURPOSE
//   Parametrised sequential priority encoder, successor to the fixed 8:3 combinational encoder.
//   Accepts a WIDTH-bit request vector over valid/ready and emits, one beat per cycle, the index of
//   every set bit in priority order. Sits between request-collection logic and a serial consumer
//   such as a scheduler or interrupt dispatcher.
// PARAMETERS
//   WIDTH      8   request vector width, >=2; IDX_W = $clog2(WIDTH) is a derived localparam
//   MSB_FIRST  1   1: highest set index first (8:3 encoder order); 0: lowest set index first
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous reset, active-low
//   in_valid   in   1          in_vec valid
//   in_ready   out  1          block can accept in_vec
//   in_vec     in   WIDTH      request vector
//   out_valid  out  1          out_idx/out_last/out_none valid
//   out_ready  in   1          consumer accepts the current beat
//   out_idx    out  IDX_W      index of current highest-priority pending bit
//   out_last   out  1          current beat is the final beat of this vector
//   out_none   out  1          captured vector was all-zero (out_idx=0)
//   busy       out  1          vector captured and not yet fully drained
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0,
//     out_none=0, busy=0; in_ready=1 once rst_n=1. Reset mid-burst discards all pending bits.
//   - FSM states IDLE, EMIT (enum from package).
//     IDLE: in_ready=1, out_valid=0. in_valid&&in_ready -> capture in_vec into pending, go EMIT.
//     EMIT: out_valid=1; out_idx = priority index of pending per MSB_FIRST.
//       out_last = (popcount(pending)<=1). out_none = (pending==0): single beat, out_idx=0, out_last=1.
//       On out_valid&&out_ready: clear bit out_idx in pending; if out_last -> IDLE (or recapture).
//   - Latency: vector accepted at edge N -> first beat valid in cycle N+1. One beat per cycle when
//     out_ready=1; a vector with k set bits takes k beats (zero vector: 1 beat).
//   - Back-to-back: in_ready = IDLE || (EMIT && out_last && out_ready). A vector accepted while the
//     last beat handshakes is captured that edge; its first beat follows next cycle, no bubble.
//   - Backpressure: while out_valid && !out_ready, out_idx/out_last/out_none and pending are held.
//   - in_vec is ignored when in_ready=0; no changes to pending except capture and bit clear.
//   - busy = (state==EMIT). All outputs registered or decoded from registered state only.
// CONFIGURATION
//   PRIO_ENC_SEQ_COUNT_EN defined: adds port out_cnt out IDX_W+1 = popcount of the captured
//     vector, loaded on capture, held constant for the whole burst, reset to 0.
//   Not defined: port and popcount register absent; all other behaviour identical.
// STRUCTURE
//   Package prio_enc_pkg: typedef enum logic {IDLE, EMIT} prio_enc_state_t; function
//     popcount for arbitrary widths.
//   Sub-module prio_enc_comb #(WIDTH, MSB_FIRST): combinational priority encoder, in vec ->
//     idx + found; instantiated once on pending.
// TESTING
//   1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_idx=0, busy=0; after release in_ready=1.
//   2 WIDTH=8, MSB_FIRST=1, in_vec=8'hA4, out_ready=1 -> idx 7,5,2 in cycles N+1..N+3, out_last on idx 2;
//     MSB_FIRST=0 same vector -> 2,5,7.
//   3 in_vec=8'h00 -> one beat: out_none=1, out_idx=0, out_last=1, then IDLE.
//   4 in_vec=8'h03, out_ready=0 for 3 cycles -> idx 1 held stable; then out_ready=1 -> 1,0.
//   5 Back-to-back 8'h80 then 8'h01 with in_valid held -> beats 7(last),0(last) consecutive cycles.
//   6 rst_n pulsed during idx 5 of 8'hA4 -> out_valid=0 immediately, no idx 2 beat; with
//     PRIO_ENC_SEQ_COUNT_EN, out_cnt=3 for 8'hA4 and 0 after reset.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Package for the sequential priority encoder: FSM state type and a
// width-agnostic popcount helper.
package prio_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } prio_enc_state_t;

   // Largest vector the popcount helper handles; callers zero-extend to this.
   localparam int POP_MAX_W = 256;
   localparam int POP_CNT_W = $clog2(POP_MAX_W) + 1;

   // Number of set bits in vec (callers cast their vector up to POP_MAX_W).
   function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
      logic [POP_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         cnt = cnt + {{(POP_CNT_W-1){1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder. MSB_FIRST=1 reports the highest set index,
// MSB_FIRST=0 the lowest. idx is 0 and found is 0 for an all-zero vector.
module prio_enc_comb #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan so that the winning bit is the last one visited: later hits overwrite.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
               idx   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures a WIDTH-bit request vector over
// valid/ready and emits the index of every set bit, one beat per cycle, in
// priority order. An all-zero vector yields a single out_none beat.
// Optional feature macro: PRIO_ENC_SEQ_COUNT_EN adds out_cnt, the popcount of
// the captured vector held for the whole burst.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready may depend combinationally on out_ready (back-to-back capture
// on the last beat); outputs are otherwise decoded from registered state only.
module prio_encoder_seq
   import prio_enc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
`ifdef PRIO_ENC_SEQ_COUNT_EN
   output logic [IDX_W:0]   out_cnt,
`endif
   output logic             busy
);

   prio_enc_state_t  state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_found;
   logic [WIDTH-1:0] clr_mask;
   logic             capture;
`ifdef PRIO_ENC_SEQ_COUNT_EN
   logic [IDX_W:0]   cnt_q, cnt_d;
`endif

   prio_enc_comb #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_enc (
      .vec   (pending_q),
      .idx   (enc_idx),
      .found (enc_found)
   );

   // One-hot mask of the bit being emitted this beat.
   assign clr_mask = WIDTH'(1) << enc_idx;

   // Next-state, pending update and handshake/output decode.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_none  = 1'b0;
      capture   = 1'b0;
`ifdef PRIO_ENC_SEQ_COUNT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_none  = !enc_found;
            out_last  = (popcount(POP_MAX_W'(pending_q)) <= POP_CNT_W'(1));
            in_ready  = out_last && out_ready;
            if (out_ready) begin
               pending_d = pending_q & ~clr_mask;
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      capture = in_valid && in_ready;
      if (capture) begin
         pending_d = in_vec;
         state_d   = EMIT;
`ifdef PRIO_ENC_SEQ_COUNT_EN
         cnt_d     = (IDX_W+1)'(popcount(POP_MAX_W'(in_vec)));
`endif
      end
   end

   // State, pending vector and optional burst popcount registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
`ifdef PRIO_ENC_SEQ_COUNT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
`ifdef PRIO_ENC_SEQ_COUNT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // pending_q is zero whenever the block is idle, so the encoder index is 0 there.
   assign out_idx = enc_idx;
   assign busy    = (state_q == EMIT);
`ifdef PRIO_ENC_SEQ_COUNT_EN
   assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Bench for prio_encoder_seq: one MSB-first and one LSB-first instance share
// the input stimulus; expected beats are queued per instance and compared as
// they handshake.
module tb_prio_encoder_seq;

  localparam int W  = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
    logic          none;
    logic [IW:0]   cnt;
  } beat_t;

  typedef struct {
    logic [W-1:0] vec;
    logic [IW:0]  cnt;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_vec = '0;
  logic          out_ready = 1'b0;

  logic          in_ready_m, out_valid_m, out_last_m, out_none_m, busy_m;
  logic [IW-1:0] out_idx_m;
  logic          in_ready_l, out_valid_l, out_last_l, out_none_l, busy_l;
  logic [IW-1:0] out_idx_l;
  logic [IW:0]   cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;

  beat_t exp_m_q[$];
  beat_t exp_l_q[$];
  beat_t em, el;
  vec_rec_t tbl[9];

  // clock
  always #5 clk = ~clk;

  prio_encoder_seq #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_idx(out_idx_m), .out_last(out_last_m), .out_none(out_none_m),
`ifdef PRIO_ENC_SEQ_COUNT_EN
    .out_cnt(cnt_m),
`endif
    .busy(busy_m)
  );

  prio_encoder_seq #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_idx(out_idx_l), .out_last(out_last_l), .out_none(out_none_l),
`ifdef PRIO_ENC_SEQ_COUNT_EN
    .out_cnt(cnt_l),
`endif
    .busy(busy_l)
  );

`ifndef PRIO_ENC_SEQ_COUNT_EN
  assign cnt_m = '0;
  assign cnt_l = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid_m && out_ready) begin
      if (exp_m_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat_m unexpected actual_idx=%0d expected=no_beat", out_idx_m);
      end else begin
        em = exp_m_q.pop_front();
        check("beat_m_idx", 32'(out_idx_m), 32'(em.idx));
        check("beat_m_last", 32'(out_last_m), 32'(em.last));
        check("beat_m_none", 32'(out_none_m), 32'(em.none));
`ifdef PRIO_ENC_SEQ_COUNT_EN
        check("beat_m_cnt", 32'(cnt_m), 32'(em.cnt));
`endif
      end
    end
    if (rst_n && out_valid_l && out_ready) begin
      if (exp_l_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat_l unexpected actual_idx=%0d expected=no_beat", out_idx_l);
      end else begin
        el = exp_l_q.pop_front();
        check("beat_l_idx", 32'(out_idx_l), 32'(el.idx));
        check("beat_l_last", 32'(out_last_l), 32'(el.last));
        check("beat_l_none", 32'(out_none_l), 32'(el.none));
`ifdef PRIO_ENC_SEQ_COUNT_EN
        check("beat_l_cnt", 32'(cnt_l), 32'(el.cnt));
`endif
      end
    end
  end

  // reference model: list set bits high-to-low for MSB-first, reverse for LSB-first
  task automatic push_model(input logic [W-1:0] v, input logic [IW:0] cnt);
    int hi[$];
    beat_t b;
    if (v == '0) begin
      b = '{idx: '0, last: 1'b1, none: 1'b1, cnt: cnt};
      exp_m_q.push_back(b);
      exp_l_q.push_back(b);
      return;
    end
    for (int i = W - 1; i >= 0; i--) if (v[i]) hi.push_back(i);
    for (int j = 0; j < hi.size(); j++) begin
      b = '{idx: IW'(hi[j]), last: (j == hi.size() - 1), none: 1'b0, cnt: cnt};
      exp_m_q.push_back(b);
      b.idx = IW'(hi[hi.size() - 1 - j]);
      exp_l_q.push_back(b);
    end
  endtask

  // driver: present v until accepted, then confirm the first beat is up next cycle
  task automatic send(input logic [W-1:0] v, input bit keep_valid);
    int n = 0;
    in_vec = v;
    in_valid = 1'b1;
    while (!in_ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_m) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high vec=%0h", v);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    @(negedge clk);
    check("first_beat_valid_m", 32'(out_valid_m), 32'd1);
    check("first_beat_busy_l", 32'({out_valid_l, busy_l}), 32'd3);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_m_q.size() != 0 || exp_l_q.size() != 0 || busy_m) && n < 300) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    out_ready = 1'b1;
    if (busy_m || exp_m_q.size() != 0 || exp_l_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual_pending=%0d expected=0", exp_m_q.size());
      exp_m_q.delete();
      exp_l_q.delete();
    end
  endtask

  initial begin
    tbl[0] = '{8'hA4, 4'd3};
    tbl[1] = '{8'h00, 4'd0};
    tbl[2] = '{8'hFF, 4'd8};
    tbl[3] = '{8'h01, 4'd1};
    tbl[4] = '{8'h80, 4'd1};
    tbl[5] = '{8'h5A, 4'd4};
    tbl[6] = '{8'h81, 4'd2};
    tbl[7] = '{8'h10, 4'd1};
    tbl[8] = '{8'h7E, 4'd6};

    // 1: reset held with in_valid asserted
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_vec = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'({out_valid_m, out_valid_l}), 32'd0);
      check("rst_out_idx", 32'(out_idx_m), 32'd0);
      check("rst_busy", 32'({busy_m, busy_l}), 32'd0);
      check("rst_last_none", 32'({out_last_m, out_none_m}), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'({in_ready_m, in_ready_l}), 32'd3);
    out_ready = 1'b1;

    // 2: 8'hA4 with fixed expectations
    exp_m_q.push_back('{3'd7, 1'b0, 1'b0, 4'd3});
    exp_m_q.push_back('{3'd5, 1'b0, 1'b0, 4'd3});
    exp_m_q.push_back('{3'd2, 1'b1, 1'b0, 4'd3});
    exp_l_q.push_back('{3'd2, 1'b0, 1'b0, 4'd3});
    exp_l_q.push_back('{3'd5, 1'b0, 1'b0, 4'd3});
    exp_l_q.push_back('{3'd7, 1'b1, 1'b0, 4'd3});
    send(8'hA4, 1'b0);
    drain();
    @(negedge clk);
    check("idle_after_a4", 32'({busy_m, out_valid_m, in_ready_m}), 32'd1);

    // 3: zero vector, single none beat
    exp_m_q.push_back('{3'd0, 1'b1, 1'b1, 4'd0});
    exp_l_q.push_back('{3'd0, 1'b1, 1'b1, 4'd0});
    send(8'h00, 1'b0);
    drain();
    @(negedge clk);
    check("idle_after_zero", 32'({busy_m, out_valid_m}), 32'd0);

    // 4: backpressure holds beat
    out_ready = 1'b0;
    push_model(8'h03, 4'd2);
    send(8'h03, 1'b0);
    repeat (3) begin
      check("hold_idx_m", 32'(out_idx_m), 32'd1);
      check("hold_idx_l", 32'(out_idx_l), 32'd0);
      check("hold_valid_last", 32'({out_valid_m, out_last_m, in_ready_m}), 32'd4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    // 5: back-to-back with in_valid held
    push_model(8'h80, 4'd1);
    send(8'h80, 1'b1);
    check("b2b_first_last", 32'({out_idx_m, out_last_m}), 32'({3'd7, 1'b1}));
    push_model(8'h01, 4'd1);
    send(8'h01, 1'b0);
    check("b2b_second_last", 32'({out_idx_m, out_last_m}), 32'({3'd0, 1'b1}));
    drain();

    // table of vectors with random output stalls
    rand_ready = 1'b1;
    for (int t = 0; t < 9; t++) begin
      push_model(tbl[t].vec, tbl[t].cnt);
      send(tbl[t].vec, 1'b0);
      drain();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // 6: reset pulse during idx 5 of 8'hA4
    push_model(8'hA4, 4'd3);
    send(8'hA4, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("pre_rst_idx5", 32'(out_idx_m), 32'd5);
`ifdef PRIO_ENC_SEQ_COUNT_EN
    check("pre_rst_cnt", 32'(cnt_m), 32'd3);
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'({out_valid_m, out_valid_l}), 32'd0);
    check("mid_rst_busy_idx", 32'({busy_m, out_idx_m}), 32'd0);
`ifdef PRIO_ENC_SEQ_COUNT_EN
    check("mid_rst_cnt", 32'(cnt_m), 32'd0);
`endif
    exp_m_q.delete();
    exp_l_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_beat_after_rst", 32'({out_valid_m, out_valid_l}), 32'd0);
      check("in_ready_after_rst", 32'(in_ready_m), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
